bfly_addsub_pipe: RTL

Parametrised radix-2 butterfly add/subtract stage with valid/ready flow control, per-beat selectable ÷2 scaling, and a per-frame peak-magnitude monitor for block-floating-point control. For each of `LANES` complex lane pairs, `a` is the delayed-branch operand and `b` is the direct operand. The block computes `a+b` and `a−b` in a 2-stage stallable pipeline. It sits between an FFT stage's delay-line shift register and its twiddle multiplier.

---
 rtl/bfly_pkg.sv | 20 ++
 rtl/bfly_lane.sv | 43 ++++
 rtl/bfly_addsub_pipe.sv | 76 +++++++
 3 files changed

// File: rtl/bfly_pkg.sv
// bfly_pkg: shared butterfly types and helpers; BFLY_ROUND_EN selects round-half-up halving instead of truncation
package bfly_pkg;
    localparam int MW = 32;
    localparam int CW = 9;
    localparam int OW = CW + 1;
    typedef struct packed {
        logic signed [OW-1:0] re;
        logic signed [OW-1:0] im;
    } cplx_t;
    function automatic logic signed [MW-1:0] scale_half(input logic signed [MW-1:0] x);
`ifdef BFLY_ROUND_EN
        return (x + 1) >>> 1;
`else
        return x >>> 1;
`endif
    endfunction
    function automatic logic [MW-1:0] abs_u(input logic signed [MW-1:0] x);
        return x < 0 ? -x : x;
    endfunction
endpackage

// File: rtl/bfly_lane.sv
// bfly_lane: one lane's full-precision add/sub register stage followed by the optional halving output stage
module bfly_lane import bfly_pkg::*; #(
    parameter int WIDTH = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s1_en,
    input  logic                    s2_en,
    input  logic                    s1_scale,
    input  logic signed [WIDTH-1:0] a_re,
    input  logic signed [WIDTH-1:0] a_im,
    input  logic signed [WIDTH-1:0] b_re,
    input  logic signed [WIDTH-1:0] b_im,
    output logic signed [WIDTH:0]   add_re,
    output logic signed [WIDTH:0]   add_im,
    output logic signed [WIDTH:0]   sub_re,
    output logic signed [WIDTH:0]   sub_im
);
    localparam int DW = WIDTH + 1;
    logic signed [DW-1:0] s1_ar, s1_ai, s1_sr, s1_si;
    function automatic logic signed [DW-1:0] sc(input logic signed [DW-1:0] x, input logic h);
        return h ? DW'(scale_half(MW'(x))) : x;
    endfunction
    always_ff @(posedge clk) begin
        if (rst) begin
            {s1_ar, s1_ai, s1_sr, s1_si} <= '0;
            {add_re, add_im, sub_re, sub_im} <= '0;
        end else begin
            if (s1_en) begin
                s1_ar <= DW'(a_re) + DW'(b_re);
                s1_ai <= DW'(a_im) + DW'(b_im);
                s1_sr <= DW'(a_re) - DW'(b_re);
                s1_si <= DW'(a_im) - DW'(b_im);
            end
            if (s2_en) begin
                add_re <= sc(s1_ar, s1_scale);
                add_im <= sc(s1_ai, s1_scale);
                sub_re <= sc(s1_sr, s1_scale);
                sub_im <= sc(s1_si, s1_scale);
            end
        end
    end
endmodule

// File: rtl/bfly_addsub_pipe.sv
// bfly_addsub_pipe: stallable 2-stage radix-2 butterfly add/sub with per-beat halving and frame peak monitor;
// BFLY_ROUND_EN selects round-half-up halving instead of truncation
module bfly_addsub_pipe import bfly_pkg::*; #(
    parameter int WIDTH = 9,
    parameter int LANES = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic                               in_last,
    input  logic                               in_scale,
    input  logic signed [LANES-1:0][WIDTH-1:0] a_re,
    input  logic signed [LANES-1:0][WIDTH-1:0] a_im,
    input  logic signed [LANES-1:0][WIDTH-1:0] b_re,
    input  logic signed [LANES-1:0][WIDTH-1:0] b_im,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               out_last,
    output logic signed [LANES-1:0][WIDTH:0]   add_re,
    output logic signed [LANES-1:0][WIDTH:0]   add_im,
    output logic signed [LANES-1:0][WIDTH:0]   sub_re,
    output logic signed [LANES-1:0][WIDTH:0]   sub_im,
    output logic [WIDTH:0]                     peak,
    output logic                               peak_valid
);
    localparam int DW = WIDTH + 1;
    logic s1_valid, s1_last, s1_scale, s1_load, s2_load, xfer;
    logic [DW-1:0] run_max, m, nxt_max;
    logic [DW-1:0] mag [4*LANES];
    assign s2_load = ~out_valid | out_ready;
    assign s1_load = ~s1_valid | s2_load;
    assign in_ready = s1_load;
    assign xfer = out_valid & out_ready;
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        bfly_lane #(.WIDTH(WIDTH)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .s1_en   (in_valid & s1_load),
            .s2_en   (s1_valid & s2_load),
            .s1_scale(s1_scale),
            .a_re    (a_re[i]),
            .a_im    (a_im[i]),
            .b_re    (b_re[i]),
            .b_im    (b_im[i]),
            .add_re  (add_re[i]),
            .add_im  (add_im[i]),
            .sub_re  (sub_re[i]),
            .sub_im  (sub_im[i])
        );
        assign mag[4*i]   = DW'(abs_u(MW'($signed(add_re[i]))));
        assign mag[4*i+1] = DW'(abs_u(MW'($signed(add_im[i]))));
        assign mag[4*i+2] = DW'(abs_u(MW'($signed(sub_re[i]))));
        assign mag[4*i+3] = DW'(abs_u(MW'($signed(sub_im[i]))));
    end
    always_comb begin
        m = '0;
        for (int k = 0; k < 4*LANES; k++) m = mag[k] > m ? mag[k] : m;
    end
    assign nxt_max = m > run_max ? m : run_max;
    always_ff @(posedge clk) begin
        if (rst) begin
            {s1_valid, s1_last, s1_scale, out_valid, out_last, peak_valid} <= '0;
            peak <= '0;
            run_max <= '0;
        end else begin
            if (s1_load) s1_valid <= in_valid;
            if (in_valid & s1_load) {s1_last, s1_scale} <= {in_last, in_scale};
            if (s2_load) out_valid <= s1_valid;
            if (s1_valid & s2_load) out_last <= s1_last;
            peak_valid <= xfer & out_last;
            if (xfer) run_max <= out_last ? '0 : nxt_max;
            if (xfer & out_last) peak <= nxt_max;
        end
    end
endmodule
